// File: rtl/throttle_guard.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// throttle_guard
//
// Safety stage between the receiver's decoded throttle (0-255) and the motor
// PWM generator. It watches the raw throttle PWM line and declares failsafe
// when pulses stop. Throttle passes through only after an arming sequence
// (throttle held low for a hold time). While armed, the rise of the motor
// rate can optionally be slew limited.
//
// Build option:
//   THROTTLE_GUARD_SLEW_EN  defined   -> upward rate slew limiting in ARMED
//                           undefined -> rate follows throttle_val with one
//                                        cycle of latency, no limit
//
// Ports:
//   us_clk        in   1  1 MHz tick clock, the only clock
//   resetn        in   1  asynchronous active-low reset
//   throttle_pwm  in   1  raw receiver throttle pulse, asynchronous
//   throttle_val  in   8  receiver-decoded throttle
//   motor_1_rate  out  8  guarded rate to the PWM generator
//   armed         out  1  high only in ARMED
//   failsafe      out  1  high only in FAILSAFE
// ---------------------------------------------------------------------------
module throttle_guard #(
  parameter int FAILSAFE_US    = 50000,
  parameter int RECOVER_PULSES = 3,
  parameter int ARM_THRESH     = 10,
`ifdef THROTTLE_GUARD_SLEW_EN
  parameter int SLEW_STEP      = 4,
  parameter int SLEW_PERIOD_US = 1000,
`endif
  parameter int ARM_HOLD_US    = 500000
) (
  input  logic       us_clk,
  input  logic       resetn,
  input  logic       throttle_pwm,
  input  logic [7:0] throttle_val,
  output logic [7:0] motor_1_rate,
  output logic       armed,
  output logic       failsafe
);

  typedef enum logic [1:0] {
    DISARMED,
    ARMING,
    ARMED,
    FAILSAFE
  } state_t;

  localparam logic [19:0] FS_LIMIT     = 20'(FAILSAFE_US);
  localparam logic [19:0] HOLD_LAST    = 20'(ARM_HOLD_US - 1);
  localparam logic [7:0]  RECOVER_LAST = 8'(RECOVER_PULSES - 1);
  localparam logic [7:0]  LOW_LIMIT    = 8'(ARM_THRESH);

  state_t      state;
  logic        pwm_meta;
  logic        pwm_sync;
  logic        pwm_prev;
  logic        edge_pulse;
  logic [19:0] loss_timer;
  logic        timeout;
  logic [19:0] hold_cnt;
  logic [7:0]  recover_cnt;
  logic        throttle_low;
  logic [7:0]  armed_rate;

  // Two-flop synchronizer for the asynchronous pulse line, plus one more
  // flop holding the previous synchronized level for edge detection.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      pwm_meta <= 1'b0;
      pwm_sync <= 1'b0;
      pwm_prev <= 1'b0;
    end else begin
      pwm_meta <= throttle_pwm;
      pwm_sync <= pwm_meta;
      pwm_prev <= pwm_sync;
    end
  end

  assign edge_pulse = pwm_sync & ~pwm_prev;

  // Loss-of-signal timer: cleared by every rising edge, otherwise counts
  // up and sticks at all-ones so a long outage can never wrap back to a
  // value below the failsafe limit.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      loss_timer <= '0;
    end else if (edge_pulse) begin
      loss_timer <= '0;
    end else if (loss_timer != '1) begin
      loss_timer <= loss_timer + 20'd1;
    end
  end

  assign timeout      = (loss_timer >= FS_LIMIT);
  assign throttle_low = (throttle_val <= LOW_LIMIT);

`ifdef THROTTLE_GUARD_SLEW_EN
  localparam logic [19:0] SLEW_LAST = 20'(SLEW_PERIOD_US - 1);
  localparam logic [8:0]  STEP9     = 9'(SLEW_STEP);

  logic [19:0] slew_cnt;
  logic        slew_tick;
  logic [8:0]  raised;

  // Slew tick generator. Held at zero outside ARMED so that the first tick
  // after arming lands a full period after the ARMED entry edge.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      slew_cnt <= '0;
    end else if (state != ARMED) begin
      slew_cnt <= '0;
    end else if (slew_tick) begin
      slew_cnt <= '0;
    end else begin
      slew_cnt <= slew_cnt + 20'd1;
    end
  end

  assign slew_tick = (slew_cnt == SLEW_LAST);
  assign raised    = {1'b0, motor_1_rate} + STEP9;

  // Next rate while armed: downward moves are immediate, upward moves step
  // on ticks. The 9-bit sum is bounded by the 8-bit target, which also
  // keeps the result at or below 255 so it can never wrap.
  always_comb begin
    armed_rate = motor_1_rate;
    if (throttle_val < motor_1_rate) begin
      armed_rate = throttle_val;
    end else if ((throttle_val > motor_1_rate) && slew_tick) begin
      if (raised > {1'b0, throttle_val}) begin
        armed_rate = throttle_val;
      end else begin
        armed_rate = raised[7:0];
      end
    end
  end
`else
  assign armed_rate = throttle_val;
`endif

  // Main state machine. Outputs are registered alongside the state so they
  // change on the same edge as the transition. A timeout overrides every
  // other transition and drops the rate to zero on that same edge.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      state        <= DISARMED;
      hold_cnt     <= '0;
      recover_cnt  <= '0;
      motor_1_rate <= '0;
      armed        <= 1'b0;
      failsafe     <= 1'b0;
    end else if (timeout) begin
      state        <= FAILSAFE;
      recover_cnt  <= '0;
      motor_1_rate <= '0;
      armed        <= 1'b0;
      failsafe     <= 1'b1;
    end else begin
      case (state)
        DISARMED: begin
          motor_1_rate <= '0;
          armed        <= 1'b0;
          failsafe     <= 1'b0;
          if (throttle_low) begin
            state    <= ARMING;
            hold_cnt <= '0;
          end
        end

        ARMING: begin
          motor_1_rate <= '0;
          failsafe     <= 1'b0;
          if (!throttle_low) begin
            state <= DISARMED;
            armed <= 1'b0;
          end else if (hold_cnt == HOLD_LAST) begin
            state <= ARMED;
            armed <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 20'd1;
            armed    <= 1'b0;
          end
        end

        ARMED: begin
          motor_1_rate <= armed_rate;
          armed        <= 1'b1;
          failsafe     <= 1'b0;
        end

        FAILSAFE: begin
          motor_1_rate <= '0;
          armed        <= 1'b0;
          // Leaving failsafe always goes through DISARMED so the pilot has
          // to re-arm deliberately.
          if (edge_pulse) begin
            if (recover_cnt == RECOVER_LAST) begin
              state       <= DISARMED;
              recover_cnt <= '0;
              failsafe    <= 1'b0;
            end else begin
              recover_cnt <= recover_cnt + 8'd1;
              failsafe    <= 1'b1;
            end
          end else begin
            failsafe <= 1'b1;
          end
        end

        default: begin
          state        <= DISARMED;
          motor_1_rate <= '0;
          armed        <= 1'b0;
          failsafe     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/throttle_guard.md
Name: throttle_guard

Overview:
Safety stage between the receiver's 0-255 throttle value and the PWM generator's motor rate input. It watches the raw throttle PWM line for loss of signal and forces failsafe when pulses stop. It requires an arming sequence (throttle held low) before passing throttle through. When armed, it limits how fast the motor rate can rise.

Parameters:
FAILSAFE_US, 50000, us without a throttle_pwm rising edge before failsafe is declared
RECOVER_PULSES, 3, consecutive on-time pulses needed to leave failsafe
ARM_THRESH, 10, throttle_val at or below this counts as "low"
ARM_HOLD_US, 500000, us throttle must stay low to arm
SLEW_STEP, 4, maximum upward rate increment per slew tick
SLEW_PERIOD_US, 1000, us between slew ticks

Ports:
us_clk  input  1  1 MHz tick clock; the block's only clock
resetn  input  1  asynchronous, active-low reset
throttle_pwm  input  1  raw receiver throttle pulse, asynchronous to us_clk
throttle_val  input  8  receiver-decoded throttle, 0-255
motor_1_rate  output  8  guarded rate to pwm_generator
armed  output  1  high only in ARMED
failsafe  output  1  high only in FAILSAFE

Behaviour:
- Reset (async, resetn low):
  - motor_1_rate=0, armed=0, failsafe=0.
  - State=DISARMED; all counters 0; synchronizer flops 0.
- Input conditioning:
  - throttle_pwm passes through a 2-flop synchronizer.
  - A rising edge is detected on the synchronized signal, giving a 1-cycle pulse 3 cycles after the pin edge.
- Loss timer (20-bit, saturating):
  - Clears on each edge pulse; otherwise increments.
  - timeout = (timer >= FAILSAFE_US).
  - Runs in every state.
- States: DISARMED, ARMING, ARMED, FAILSAFE.
  - Any state -> FAILSAFE when timeout; this has priority over all other transitions in the same cycle.
  - DISARMED -> ARMING when throttle_val <= ARM_THRESH. The hold counter clears.
  - ARMING:
    - Hold counter (20-bit) increments each cycle.
    - throttle_val > ARM_THRESH -> DISARMED.
    - Hold counter reaches ARM_HOLD_US-1 with throttle still low -> ARMED.
  - ARMED: stays until timeout. High throttle never disarms.
  - FAILSAFE:
    - The recover counter increments on each edge pulse.
    - Entry, or any cycle with timer >= FAILSAFE_US, clears the recover counter.
    - Count reaches RECOVER_PULSES -> DISARMED. Re-arming is always required after a failsafe.
- Outputs (registered, updated the cycle after the state/condition):
  - armed = (state==ARMED); failsafe = (state==FAILSAFE).
  - motor_1_rate forced to 0 in every state except ARMED, and on the transition out of ARMED (same edge as the state change).
- Slew in ARMED:
  - A slew counter generates a 1-cycle tick every SLEW_PERIOD_US cycles. It free-runs and resets to 0 on entry to ARMED.
  - target = throttle_val.
  - If target < rate: rate = target immediately, every cycle (downward unlimited).
  - If target > rate on a tick: rate = min(rate+SLEW_STEP, target). Compute in 9 bits and clamp to 255; no wrap.
  - Equal: hold.
- Arming hold plus throttle at 0 means the first ARMED output is 0.

Optional Feature:
THROTTLE_GUARD_SLEW_EN
- Defined: upward slew limiting as described.
- Undefined: in ARMED, motor_1_rate = throttle_val registered every cycle (1-cycle latency, no limit). The slew counter and its logic are not built.
- Arming and failsafe behaviour are identical in both builds.

Test Plan:
- Reset, 50 Hz pulses, throttle_val=0 held 500000 cycles -> armed=1 at cycle 500001 after entering ARMING; motor_1_rate=0.
- During ARMING, throttle_val steps to 11 at cycle 300000 -> back to DISARMED, armed=0. Returning to 0 restarts the full 500000-cycle hold.
- Armed, throttle_val steps 0->200 (slew enabled) -> rate 4,8,… every 1000 cycles, reaching 200 after 50 ticks. Step 200->20 -> rate=20 the next cycle.
- Armed at rate 200, pulses stop -> failsafe=1, armed=0, rate=0 at FAILSAFE_US+1 cycles after the last edge. 3 on-time pulses -> DISARMED; rate stays 0 until re-armed.
- Armed at rate 254, SLEW_STEP=4, target 255 -> rate 255, no wrap. resetn pulsed low mid-ramp -> outputs 0 asynchronously, state DISARMED.
- Build without THROTTLE_GUARD_SLEW_EN, armed, throttle_val 0->200 -> motor_1_rate=200 one cycle later.
